// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants, receiver state type and parity helper
package ps2_pkg;

   // start + 8 data + parity + stop
   localparam int PS2_FRAME_BITS = 11;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_t;

   // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered pointers and occupancy count
// clk    in   system clock
// clrn   in   asynchronous active-low reset
// push   in   write wdata this cycle (caller must not push while full unless popping)
// wdata  in   WIDTH-bit write data
// pop    in   read request; ignored while empty
// rdata  out  head entry (undefined while empty)
// empty  out  no entries stored
// full   out  2**DEPTH_LOG2 entries stored
// count  out  number of stored entries
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  clrn,
   input  logic                  push,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  pop,
   output logic [WIDTH-1:0]      rdata,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic                  wr_en;
   logic                  rd_en;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign wr_en = push;
   assign rd_en = pop & ~empty;
   assign rdata = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_en) begin
            rptr <= rptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with frame checking and scan-code FIFO
// clk         in   system clock
// clrn        in   asynchronous active-low reset
// ps2_clk     in   raw PS/2 clock pin (asynchronous)
// ps2_data    in   raw PS/2 data pin (asynchronous)
// nextdata_n  in   active-low pop strobe, one entry per low cycle
// data        out  FIFO head byte, 8'h00 while empty
// ready       out  FIFO not empty
// overflow    out  sticky: a good frame was dropped on a full FIFO
// frame_err   out  one-cycle pulse when a frame is discarded
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH_LOG2  = 3,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
   // bitcnt is 1 after the start bit, so the stop bit arrives with bitcnt == 10
   localparam logic [3:0]    LAST_FALL = 4'(PS2_FRAME_BITS - 1);

   logic clk_s1, clk_s2, clk_s3;
   logic data_s1, data_s2;
   logic fall;

   rx_state_t     state, state_n;
   logic [3:0]    bitcnt, bitcnt_n;
   logic [8:0]    shreg, shreg_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic          push_req;
   logic          err_n;

   logic                fifo_push;
   logic                pop_ok;
   logic [7:0]          fifo_rdata;
   logic                fifo_empty;
   logic                fifo_full;
   logic [DEPTH_LOG2:0] fifo_count;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         clk_s3  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         clk_s3  <= clk_s2;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
      end
   end

   assign fall = clk_s3 & ~clk_s2;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state     <= IDLE;
         bitcnt    <= '0;
         shreg     <= '0;
         tcnt      <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         bitcnt    <= bitcnt_n;
         shreg     <= shreg_n;
         tcnt      <= tcnt_n;
         frame_err <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      shreg_n  = shreg;
      tcnt_n   = tcnt;
      push_req = 1'b0;
      err_n    = 1'b0;
      case (state)
         IDLE: begin
            if (fall && !data_s2) begin
               bitcnt_n = 4'd1;
               tcnt_n   = '0;
               state_n  = SHIFT;
            end
         end
         SHIFT: begin
            if (fall) begin
               tcnt_n = '0;
               if (bitcnt == LAST_FALL) begin
                  // shreg holds {parity, d7..d0}; data_s2 is the stop bit
                  state_n  = IDLE;
                  bitcnt_n = '0;
                  if (data_s2 && odd_parity_ok(shreg[7:0], shreg[8])) begin
                     push_req = 1'b1;
                  end else begin
                     err_n = 1'b1;
                  end
               end else begin
                  shreg_n  = {data_s2, shreg[8:1]};
                  bitcnt_n = bitcnt + 4'd1;
               end
            end else if (tcnt == TO_LAST) begin
               state_n  = IDLE;
               bitcnt_n = '0;
               tcnt_n   = '0;
               err_n    = 1'b1;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
         end
      endcase
   end

   // A full FIFO still accepts a byte when the same edge pops one.
   assign pop_ok    = ~nextdata_n & ~fifo_empty;
   assign fifo_push = push_req & (~fifo_full | pop_ok);

   sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .clrn  (clrn),
      .push  (fifo_push),
      .wdata (shreg[7:0]),
      .pop   (~nextdata_n),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         overflow <= 1'b0;
      end else if (pop_ok) begin
         overflow <= 1'b0;
      end else if (push_req && fifo_full) begin
         overflow <= 1'b1;
      end
   end

   assign ready = (fifo_count != '0);
   assign data  = fifo_empty ? 8'h00 : fifo_rdata;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

   localparam int TO    = 300;
   localparam int DEPTH = 8;
   localparam int HALF  = 10;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       nextdata_n = 1'b1;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   always #5 clk = ~clk;

   ps2_rx_fifo #(
      .DEPTH_LOG2  (3),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   int         checks = 0;
   int         failures = 0;
   logic [7:0] q[$];
   bit         m_ovf = 1'b0;
   int         err_exp = 0;
   int         err_seen = 0;
   bit         check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_ready", {31'd0, ready}, {31'd0, q.size() != 0});
         chk("cyc_data", {24'd0, data}, {24'd0, (q.size() != 0) ? q[0] : 8'h00});
         chk("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      end
   end

   always @(negedge clk) begin
      if (clrn && frame_err === 1'b1) err_seen++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic bit good_par(input logic [7:0] d);
      return ~(^d);
   endfunction

   task automatic model_frame(input logic [7:0] d, input bit par, input bit stop);
      if (stop && ((^d) ^ par)) begin
         if (q.size() == DEPTH) m_ovf = 1'b1;
         else q.push_back(d);
      end else begin
         err_exp++;
      end
   endtask

   // nfalls = 11 is a whole frame; fewer leaves the frame unfinished
   task automatic send_frame(input logic [7:0] d, input bit par, input bit stop, input int nfalls);
      logic [10:0] f;
      f = {stop, par, d, 1'b0};
      for (int i = 0; i < nfalls; i++) begin
         ps2_data = f[i];
         cyc(HALF);
         if (i == 10) check_en = 1'b0;
         ps2_clk = 1'b0;
         cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      if (nfalls == 11) begin
         model_frame(d, par, stop);
         check_en = 1'b1;
      end
      cyc(HALF);
   endtask

   task automatic good(input logic [7:0] d);
      send_frame(d, good_par(d), 1'b1, 11);
   endtask

   task automatic pop();
      nextdata_n = 1'b0;
      check_en = 1'b0;
      cyc(1);
      nextdata_n = 1'b1;
      if (q.size() != 0) begin
         void'(q.pop_front());
         m_ovf = 1'b0;
      end
      check_en = 1'b1;
      cyc(1);
   endtask

   task automatic err_point(input string name);
      chk(name, err_seen, err_exp);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(3);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_data", {24'd0, data}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      clrn = 1'b1;
      cyc(3);
      check_en = 1'b1;

      // 1: single good frame
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      chk("t1_ready", {31'd0, ready}, 32'd1);
      chk("t1_data", {24'd0, data}, 32'h1C);
      pop();
      chk("t1_ready_after_pop", {31'd0, ready}, 32'd0);

      // 2: three queued bytes
      good(8'h1C); good(8'hF0); good(8'h1C);
      chk("t2_model_count", q.size(), 32'd3);
      chk("t2_head0", {24'd0, data}, 32'h1C); pop();
      chk("t2_head1", {24'd0, data}, 32'hF0); pop();
      chk("t2_head2", {24'd0, data}, 32'h1C); pop();
      chk("t2_overflow", {31'd0, overflow}, 32'd0);
      chk("t2_empty", {31'd0, ready}, 32'd0);

      // 3: bad parity, bad stop, then good frame
      send_frame(8'h1C, 1'b1, 1'b1, 11);
      err_point("t3_err_parity");
      chk("t3_err_lit", err_seen, 32'd1);
      chk("t3_ready", {31'd0, ready}, 32'd0);
      send_frame(8'h32, 1'b0, 1'b0, 11);
      err_point("t3_err_stop");
      good(8'h32);
      chk("t3_data", {24'd0, data}, 32'h32);
      pop();

      // 4: fill, overflow, drain
      for (int k = 1; k <= 9; k++) good(8'(k));
      chk("t4_model_count", q.size(), 32'd8);
      chk("t4_overflow", {31'd0, overflow}, 32'd1);
      chk("t4_head", {24'd0, data}, 32'h01);
      pop();
      chk("t4_pop_data", {24'd0, data}, 32'h02);
      chk("t4_pop_ovf", {31'd0, overflow}, 32'd0);
      for (int k = 2; k <= 8; k++) begin
         chk("t4_drain", {24'd0, data}, k);
         pop();
      end
      chk("t4_empty", {31'd0, ready}, 32'd0);
      err_point("t4_err");

      // 5: truncated frame times out
      send_frame(8'h00, 1'b0, 1'b1, 5);
      err_point("t5_no_early_err");
      cyc(TO + 20);
      err_exp++;
      err_point("t5_timeout_err");
      chk("t5_ready", {31'd0, ready}, 32'd0);
      good(8'h5A);
      chk("t5_data", {24'd0, data}, 32'h5A);
      pop();

      // 6: reset mid-frame with bytes queued
      good(8'h11); good(8'h22); good(8'h33);
      chk("t6_queued", {24'd0, data}, 32'h11);
      send_frame(8'hFF, 1'b0, 1'b1, 4);
      clrn = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      #1;
      chk("t6_rst_ready", {31'd0, ready}, 32'd0);
      chk("t6_rst_data", {24'd0, data}, 32'd0);
      chk("t6_rst_overflow", {31'd0, overflow}, 32'd0);
      cyc(3);
      clrn = 1'b1;
      cyc(3);
      good(8'h45);
      chk("t6_data", {24'd0, data}, 32'h45);
      err_point("t6_no_err");
      pop();
      chk("t6_empty", {31'd0, ready}, 32'd0);

      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
